// File: rtl/rv32i_ctrl_pkg.sv
// Opcode encodings, ALUOp/ALUASrc codes and the packed control word for the
// RV32I main decoder.
package rv32i_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] ASRC_RS1  = 2'b00;
  localparam logic [1:0] ASRC_PC   = 2'b01;
  localparam logic [1:0] ASRC_ZERO = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_a_src;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr_sel;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/control_unit.sv
// RV32I main decoder: opcode -> datapath strobes, zero latency, plus a sticky
// illegal-opcode flag. Define CTRL_SYSTEM_NOP_EN to accept FENCE/SYSTEM as NOPs.
module control_unit
  import rv32i_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic [1:0] ALUASrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       JalrSel,
  output logic       MemToReg,
  output logic       PcToReg,
  output logic [1:0] ALUOp,
  output logic       illegal_op,
  output logic       illegal_seen
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t ctrl;
  logic  illegal_seen_d, illegal_seen_q;

  always_comb begin
    dec_ctrl    = ctrl_nop();
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ITYPE;
      end
      OP_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALUOP_BRANCH;
      end
      OP_LUI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_a_src = ASRC_ZERO;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_AUIPC: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_a_src = ASRC_PC;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_JAL: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.pc_to_reg = 1'b1;
        dec_ctrl.alu_a_src = ASRC_PC;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
      OP_JALR: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.jalr_sel  = 1'b1;
        dec_ctrl.pc_to_reg = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_ADD;
      end
`ifdef CTRL_SYSTEM_NOP_EN
      OP_FENCE, OP_SYSTEM: begin
        dec_illegal = 1'b0;
      end
`endif
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Reset gates every combinational output so the core issues NOPs during reset.
  always_comb begin
    ctrl       = rst ? ctrl_nop() : dec_ctrl;
    illegal_op = rst ? 1'b0 : dec_illegal;
  end

  assign RegWrite = ctrl.reg_write;
  assign ALUSrc   = ctrl.alu_src;
  assign ALUASrc  = ctrl.alu_a_src;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign Jump     = ctrl.jump;
  assign JalrSel  = ctrl.jalr_sel;
  assign MemToReg = ctrl.mem_to_reg;
  assign PcToReg  = ctrl.pc_to_reg;
  assign ALUOp    = ctrl.alu_op;

  always_comb begin
    illegal_seen_d = illegal_seen_q | illegal_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomised checks of the RV32I main decoder.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       RegWrite, ALUSrc, MemRead, MemWrite, Branch, Jump, JalrSel;
  logic       MemToReg, PcToReg, illegal_op, illegal_seen;
  logic [1:0] ALUASrc, ALUOp;

  int n_cmp;
  int n_fail;

  // {RegWrite,ALUSrc,ALUASrc,MemRead,MemWrite,Branch,Jump,JalrSel,MemToReg,PcToReg,ALUOp,illegal_op}
  logic [13:0] obs;
  assign obs = {RegWrite, ALUSrc, ALUASrc, MemRead, MemWrite, Branch, Jump, JalrSel,
                MemToReg, PcToReg, ALUOp, illegal_op};

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .ALUASrc     (ALUASrc),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Branch      (Branch),
    .Jump        (Jump),
    .JalrSel     (JalrSel),
    .MemToReg    (MemToReg),
    .PcToReg     (PcToReg),
    .ALUOp       (ALUOp),
    .illegal_op  (illegal_op),
    .illegal_seen(illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [13:0] EXP_NOP     = 14'b0_0_00_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] EXP_ILLEGAL = 14'b0_0_00_0_0_0_0_0_0_0_00_1;

  task automatic test_reset();
    @(negedge clk);
    rst    = 1'b1;
    opcode = 7'b0110011;
    #1;
    n_cmp++;
    if (obs !== EXP_NOP) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs, EXP_NOP);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_seen: got %b expected 0", illegal_seen);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [6:0]  ops  [9];
    logic [13:0] exps [9];
    ops[0] = 7'b0110011; exps[0] = 14'b1_0_00_0_0_0_0_0_0_0_10_0;  // R
    ops[1] = 7'b0010011; exps[1] = 14'b1_1_00_0_0_0_0_0_0_0_11_0;  // I-ALU
    ops[2] = 7'b0000011; exps[2] = 14'b1_1_00_1_0_0_0_0_1_0_00_0;  // load
    ops[3] = 7'b0100011; exps[3] = 14'b0_1_00_0_1_0_0_0_0_0_00_0;  // store
    ops[4] = 7'b1100011; exps[4] = 14'b0_0_00_0_0_1_0_0_0_0_01_0;  // branch
    ops[5] = 7'b0110111; exps[5] = 14'b1_1_10_0_0_0_0_0_0_0_00_0;  // LUI
    ops[6] = 7'b0010111; exps[6] = 14'b1_1_01_0_0_0_0_0_0_0_00_0;  // AUIPC
    ops[7] = 7'b1101111; exps[7] = 14'b1_1_01_0_0_0_1_0_0_1_00_0;  // JAL
    ops[8] = 7'b1100111; exps[8] = 14'b1_1_00_0_0_0_1_1_0_1_00_0;  // JALR
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      opcode = ops[i];
      #1;
      n_cmp++;
      if (obs !== exps[i]) begin
        n_fail++;
        $display("FAIL decode_%b: got %b expected %b", ops[i], obs, exps[i]);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL seen_after_legal: got %b expected 0", illegal_seen);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [3];
    ops[0] = 7'b0000000;
    ops[1] = 7'b1111111;
    ops[2] = 7'b0110001;  // R-type with low bits != 11
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = ops[i];
      #1;
      n_cmp++;
      if (obs !== EXP_ILLEGAL) begin
        n_fail++;
        $display("FAIL illegal_%b: got %b expected %b", ops[i], obs, EXP_ILLEGAL);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL seen_set: got %b expected 1", illegal_seen);
    end
    @(negedge clk);
    opcode = 7'b0110011;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL seen_sticky: got %b expected 1", illegal_seen);
    end
  endtask

  task automatic test_reset_clear();
    @(negedge clk);
    rst    = 1'b1;
    opcode = 7'b0000000;
    #1;
    n_cmp++;
    if (obs !== EXP_NOP) begin
      n_fail++;
      $display("FAIL reset_gates_illegal: got %b expected %b", obs, EXP_NOP);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_seen: got %b expected 0", illegal_seen);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_in_reset: got %b expected 0", illegal_seen);
    end
    @(negedge clk);
    rst    = 1'b0;
    opcode = 7'b0000011;
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL seen_after_release: got %b expected 0", illegal_seen);
    end
  endtask

  task automatic test_system_nop();
    logic [6:0]  ops [2];
    logic [13:0] exp_v;
    logic        exp_seen;
    ops[0] = 7'b0001111;
    ops[1] = 7'b1110011;
`ifdef CTRL_SYSTEM_NOP_EN
    exp_v    = EXP_NOP;
    exp_seen = 1'b0;
`else
    exp_v    = EXP_ILLEGAL;
    exp_seen = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      opcode = ops[i];
      #1;
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL sysop_%b: got %b expected %b", ops[i], obs, exp_v);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (illegal_seen !== exp_seen) begin
      n_fail++;
      $display("FAIL sysop_seen: got %b expected %b", illegal_seen, exp_seen);
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    logic       legal;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      op     = 7'($urandom_range(0, 127));
      opcode = op;
      #1;
      legal = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
              (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b0110111) ||
              (op == 7'b0010111) || (op == 7'b1101111) || (op == 7'b1100111);
`ifdef CTRL_SYSTEM_NOP_EN
      legal = legal || (op == 7'b0001111) || (op == 7'b1110011);
`endif
      n_cmp++;
      if ((MemRead & MemWrite) !== 1'b0 || (Branch & Jump) !== 1'b0 ||
          (((op == 7'b0100011) || (op == 7'b1100011)) && RegWrite !== 1'b0) ||
          ALUASrc === 2'b11 || illegal_op !== !legal ||
          (!legal && obs !== EXP_ILLEGAL)) begin
        n_fail++;
        $display("FAIL random_%b: got %b illegal_op expected %b", op, obs, !legal);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    opcode = 7'b0000000;
    test_reset();
    test_decode();
    test_illegal();
    test_reset_clear();
    test_system_nop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
